// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: START / repeated START / STOP / WRITE / READ over open-drain SCL/SDA,
// with programmable quarter-period timing and slave clock stretching.
module i2c_byte_master #(
    parameter int CLK_DIV = 25
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [2:0] cmd_i,
    input  logic [7:0] wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rdata_o,
    output logic       ack_o,
    output logic       err_o,
    output logic       bus_owned_o,
    output logic       scl_o,
    output logic       sda_o,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic [2:0] dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_STOP  = 3'd2,
        S_BIT   = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [9:0] DIV_M1 = 10'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [1:0] quarter_q, quarter_d;
    logic [9:0] cnt_q, cnt_d;
    logic [3:0] bit_q, bit_d;
    logic [2:0] cmd_q, cmd_d;
    logic [8:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic       ack_smp_q, ack_smp_d;
    logic       err_pend_q, err_pend_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       err_q, err_d;
    logic       ack_q, ack_d;
    logic [7:0] rdata_q, rdata_d;
    logic       owned_q, owned_d;
    logic       scl_q, scl_d;
    logic       sda_q, sda_d;
    logic       scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d;
    logic       sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d;
    logic       stall;

    // Handshake: a command is taken when cmd_valid_i && cmd_ready_o. Ready is high exactly
    // in IDLE, which is also the rsp_valid_o cycle, so commands can chain with no gap.
    assign cmd_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign err_o       = err_q;
    assign ack_o       = ack_q;
    assign rdata_o     = rdata_q;
    assign bus_owned_o = owned_q;
    assign scl_o       = scl_q;
    assign sda_o       = sda_q;
    assign dbg_state_o = state_q;

    // A slave holding SCL low at the end of Q1 freezes the quarter counter.
    assign stall = (quarter_q == 2'd1) && !scl_s2_q;

    always_comb begin
        state_d     = state_q;
        quarter_d   = quarter_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        cmd_d       = cmd_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        ack_smp_d   = ack_smp_q;
        err_pend_d  = err_pend_q;
        rsp_valid_d = 1'b0;
        err_d       = 1'b0;
        ack_d       = ack_q;
        rdata_d     = rdata_q;
        owned_d     = owned_q;
        scl_s1_d    = scl_i;
        scl_s2_d    = scl_s1_q;
        sda_s1_d    = sda_i;
        sda_s2_d    = sda_s1_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    cmd_d      = cmd_i;
                    quarter_d  = 2'd0;
                    cnt_d      = 10'd0;
                    bit_d      = 4'd8;
                    err_pend_d = 1'b0;
                    case (cmd_i)
                        3'd0: state_d = S_START;
                        3'd1: begin
                            if (owned_q) state_d = S_STOP;
                            else begin
                                state_d    = S_RESP;
                                err_pend_d = 1'b1;
                            end
                        end
                        3'd2, 3'd3, 3'd4: begin
                            if (owned_q) begin
                                state_d = S_BIT;
                                tx_d    = (cmd_i == 3'd2) ? {wdata_i, 1'b1}
                                                          : {8'hFF, (cmd_i == 3'd4)};
                            end else begin
                                state_d    = S_RESP;
                                err_pend_d = 1'b1;
                            end
                        end
                        default: begin
                            state_d    = S_RESP;
                            err_pend_d = 1'b1;
                        end
                    endcase
                end
            end
            S_START, S_STOP, S_BIT: begin
                if (state_q == S_BIT && quarter_q == 2'd2 && cnt_q == 10'd0) begin
                    if (bit_q == 4'd0) ack_smp_d = ~sda_s2_q;
                    else               rx_d      = {rx_q[6:0], sda_s2_q};
                end
                if (cnt_q != DIV_M1) begin
                    cnt_d = cnt_q + 10'd1;
                end else if (!stall) begin
                    cnt_d     = 10'd0;
                    quarter_d = quarter_q + 2'd1;
                    if (quarter_q == 2'd3) begin
                        if (state_q == S_START) begin
                            state_d = S_RESP;
                            owned_d = 1'b1;
                        end else if (state_q == S_STOP) begin
                            state_d = S_RESP;
                            owned_d = 1'b0;
                        end else if (bit_q == 4'd0) begin
                            state_d = S_RESP;
                        end else begin
                            bit_d = bit_q - 4'd1;
                        end
                    end
                end
            end
            S_RESP: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                err_d       = err_pend_q;
                if (!err_pend_q) begin
                    if (cmd_q == 3'd2) ack_d = ack_smp_q;
                    if (cmd_q == 3'd3 || cmd_q == 3'd4) rdata_d = rx_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pins are registered from the next state so they line up with quarter boundaries;
        // outside bus phases they simply hold.
        scl_d = scl_q;
        sda_d = sda_q;
        case (state_d)
            S_START: begin
                scl_d = (quarter_d == 2'd1) || (quarter_d == 2'd2);
                sda_d = (quarter_d == 2'd0) || (quarter_d == 2'd1);
            end
            S_STOP: begin
                scl_d = (quarter_d != 2'd0);
                sda_d = (quarter_d == 2'd2) || (quarter_d == 2'd3);
            end
            S_BIT: begin
                scl_d = (quarter_d == 2'd1) || (quarter_d == 2'd2);
                sda_d = tx_d[bit_d];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            quarter_q   <= 2'd0;
            cnt_q       <= 10'd0;
            bit_q       <= 4'd0;
            cmd_q       <= 3'd0;
            tx_q        <= 9'h1FF;
            rx_q        <= 8'h00;
            ack_smp_q   <= 1'b0;
            err_pend_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            ack_q       <= 1'b0;
            rdata_q     <= 8'h00;
            owned_q     <= 1'b0;
            scl_q       <= 1'b1;
            sda_q       <= 1'b1;
            scl_s1_q    <= 1'b1;
            scl_s2_q    <= 1'b1;
            sda_s1_q    <= 1'b1;
            sda_s2_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            quarter_q   <= quarter_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            cmd_q       <= cmd_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            ack_smp_q   <= ack_smp_d;
            err_pend_q  <= err_pend_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            owned_q     <= owned_d;
            scl_q       <= scl_d;
            sda_q       <= sda_d;
            scl_s1_q    <= scl_s1_d;
            scl_s2_q    <= scl_s2_d;
            sda_s1_q    <= sda_s1_d;
            sda_s2_q    <= sda_s2_d;
        end
    end

endmodule
